// File: rtl/dru_pkg.sv
// Shared definitions for the DRU lock controller: state encoding and input widths.
package dru_pkg;

    // Width of the DRU edge-position flag vector E[3:0].
    localparam int EDGE_W = 4;

    // Width of the DRU phase-select state.
    localparam int PHASE_W = 2;

    // Controller state, encoded exactly as reported on ctrl_state.
    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2,
        ST_FAIL   = 2'd3
    } ctrl_state_t;

    // True in the states where the DRU runs and windows are evaluated.
    function automatic logic state_running(input ctrl_state_t st);
        return (st == ST_ACQ) || (st == ST_LOCKED);
    endfunction

endpackage

// File: rtl/dru_window_eval.sv
// Fixed-length window evaluator: counts edge cycles and phase slips over
// 2^WIN_LOG2 cycles and flags the last cycle of each window with its verdict.
module dru_window_eval
    import dru_pkg::*;
#(
    parameter int WIN_LOG2  = 8,
    parameter int MIN_EDGES = 16,
    parameter int MAX_SLIPS = 4
) (
    input  logic               clk,
    input  logic               areset,
    input  logic               clear,
    input  logic [EDGE_W-1:0]  edge_flags,
    input  logic [PHASE_W-1:0] dru_phase,
    output logic               win_end,
    output logic               win_good
);

    // Counters are one bit wider than the window index so they can hold 2^WIN_LOG2.
    localparam int CW = WIN_LOG2 + 1;
    localparam logic [CW-1:0] CNT_MAX = {1'b1, {WIN_LOG2{1'b0}}};
    localparam logic [CW-1:0] MIN_E   = CW'(MIN_EDGES);
    localparam logic [CW-1:0] MAX_S   = CW'(MAX_SLIPS);

    logic [WIN_LOG2-1:0] win_cnt;
    logic [CW-1:0]       edge_cnt;
    logic [CW-1:0]       slip_cnt;
    logic [PHASE_W-1:0]  prev_phase;
    logic                is_edge;
    logic                is_slip;
    logic [CW-1:0]       edge_tot;
    logic [CW-1:0]       slip_tot;

    // Saturating increment, capped at the window length.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt, input logic inc);
        if (inc && (cnt != CNT_MAX)) begin
            return cnt + 1'b1;
        end
        return cnt;
    endfunction

    assign is_edge  = |edge_flags;
    assign is_slip  = (dru_phase != prev_phase);
    assign edge_tot = sat_inc(edge_cnt, is_edge);
    assign slip_tot = sat_inc(slip_cnt, is_slip);
    assign win_end  = &win_cnt;
    // Verdict includes the flags of the last window cycle itself.
    assign win_good = (edge_tot >= MIN_E) && (slip_tot <= MAX_S);

    // Window index, per-window tallies and previous phase; while cleared the
    // previous phase keeps tracking the DRU so entering ACQ sees no false slip.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            win_cnt    <= '0;
            edge_cnt   <= '0;
            slip_cnt   <= '0;
            prev_phase <= '0;
        end else if (clear) begin
            win_cnt    <= '0;
            edge_cnt   <= '0;
            slip_cnt   <= '0;
            prev_phase <= dru_phase;
        end else begin
            win_cnt    <= win_cnt + 1'b1;
            prev_phase <= dru_phase;
            if (win_end) begin
                edge_cnt <= '0;
                slip_cnt <= '0;
            end else begin
                edge_cnt <= edge_tot;
                slip_cnt <= slip_tot;
            end
        end
    end

endmodule

// File: rtl/dru_lock_ctrl.sv
// Lock controller for the oversampling DRU: holds it in reset, acquires lock
// over evaluation windows, detects loss of lock and retries a bounded number of times.
module dru_lock_ctrl
    import dru_pkg::*;
#(
    parameter int RST_CYCLES   = 16,
    parameter int WIN_LOG2     = 8,
    parameter int MIN_EDGES    = 16,
    parameter int MAX_SLIPS    = 4,
    parameter int LOCK_WINDOWS = 4,
    parameter int LOSS_WINDOWS = 2,
    parameter int ACQ_TIMEOUT  = 16,
    parameter int MAX_RETRIES  = 7
) (
    input  logic               clk,
    input  logic               areset,
    input  logic               restart,
    input  logic [EDGE_W-1:0]  edge_flags,
    input  logic [PHASE_W-1:0] dru_phase,
    output logic               dru_aresetn,
    output logic               locked,
    output logic               lock_lost,
    output logic               fail,
    output logic [2:0]         retry_cnt,
    output logic [1:0]         ctrl_state
);

    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int GCW = $clog2(LOCK_WINDOWS + 1);
    localparam int BCW = $clog2(LOSS_WINDOWS + 1);
    localparam int TCW = $clog2(ACQ_TIMEOUT + 1);

    localparam logic [RCW-1:0] RST_LAST  = RCW'(RST_CYCLES - 1);
    localparam logic [GCW-1:0] LOCK_N    = GCW'(LOCK_WINDOWS);
    localparam logic [BCW-1:0] LOSS_N    = BCW'(LOSS_WINDOWS);
    localparam logic [TCW-1:0] TMO_N     = TCW'(ACQ_TIMEOUT);
    localparam logic [2:0]     RETRY_MAX = 3'(MAX_RETRIES);

    ctrl_state_t    state_q, state_d;
    logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
    logic [GCW-1:0] good_cnt_q, good_cnt_d;
    logic [BCW-1:0] bad_cnt_q, bad_cnt_d;
    logic [TCW-1:0] acq_win_q, acq_win_d;
    logic [2:0]     retry_q, retry_d;
    logic           lost_d;
    logic           win_end;
    logic           win_good;
    logic           win_clear;

    // The evaluator is held clear whenever the DRU is not running, and also on
    // the restart edge so no stale tally survives an abort.
    assign win_clear = restart || !state_running(state_q);

    dru_window_eval #(
        .WIN_LOG2  (WIN_LOG2),
        .MIN_EDGES (MIN_EDGES),
        .MAX_SLIPS (MAX_SLIPS)
    ) u_window_eval (
        .clk        (clk),
        .areset     (areset),
        .clear      (win_clear),
        .edge_flags (edge_flags),
        .dru_phase  (dru_phase),
        .win_end    (win_end),
        .win_good   (win_good)
    );

    // Next-state and counter updates; restart outranks any window verdict.
    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        acq_win_d  = acq_win_q;
        retry_d    = retry_q;
        lost_d     = 1'b0;

        if (restart) begin
            state_d    = ST_RESET;
            rst_cnt_d  = '0;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
            acq_win_d  = '0;
            retry_d    = '0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    good_cnt_d = '0;
                    bad_cnt_d  = '0;
                    acq_win_d  = '0;
                    if (rst_cnt_q == RST_LAST) begin
                        state_d   = ST_ACQ;
                        rst_cnt_d = '0;
                    end else begin
                        rst_cnt_d = rst_cnt_q + 1'b1;
                    end
                end
                ST_ACQ: begin
                    if (win_end) begin
                        good_cnt_d = win_good ? (good_cnt_q + 1'b1) : '0;
                        acq_win_d  = acq_win_q + 1'b1;
                        if (good_cnt_d == LOCK_N) begin
                            state_d    = ST_LOCKED;
                            retry_d    = '0;
                            good_cnt_d = '0;
                            bad_cnt_d  = '0;
                            acq_win_d  = '0;
                        end else if (acq_win_d == TMO_N) begin
                            retry_d    = retry_q + 1'b1;
                            good_cnt_d = '0;
                            acq_win_d  = '0;
                            state_d    = (retry_d == RETRY_MAX) ? ST_FAIL : ST_RESET;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (win_end) begin
                        bad_cnt_d = win_good ? '0 : (bad_cnt_q + 1'b1);
                        if (bad_cnt_d == LOSS_N) begin
                            state_d   = ST_RESET;
                            lost_d    = 1'b1;
                            bad_cnt_d = '0;
                        end
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_RESET;
                end
            endcase
        end
    end

    // State, counters and registered outputs; outputs decode the next state so
    // they change on the same edge as ctrl_state.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q     <= ST_RESET;
            rst_cnt_q   <= '0;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            acq_win_q   <= '0;
            retry_q     <= '0;
            dru_aresetn <= 1'b0;
            locked      <= 1'b0;
            lock_lost   <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            acq_win_q   <= acq_win_d;
            retry_q     <= retry_d;
            dru_aresetn <= state_running(state_d);
            locked      <= (state_d == ST_LOCKED);
            lock_lost   <= lost_d;
            fail        <= (state_d == ST_FAIL);
        end
    end

    assign retry_cnt  = retry_q;
    assign ctrl_state = state_q;

endmodule

// File: tb/tb_dru_lock_ctrl.sv
// Self-checking bench for dru_lock_ctrl: scenario table, async-reset check and
// randomized traffic against a window-queue reference model.
module tb_dru_lock_ctrl;

    localparam int RST_CYCLES   = 4;
    localparam int WIN_LOG2     = 4;
    localparam int MIN_EDGES    = 4;
    localparam int MAX_SLIPS    = 1;
    localparam int LOCK_WINDOWS = 2;
    localparam int LOSS_WINDOWS = 2;
    localparam int ACQ_TIMEOUT  = 3;
    localparam int MAX_RETRIES  = 2;
    localparam int WIN          = 1 << WIN_LOG2;

    logic       clk = 1'b0;
    logic       areset = 1'b1;
    logic       restart = 1'b0;
    logic [3:0] edge_flags = 4'b0;
    logic [1:0] dru_phase = 2'b0;
    logic       dru_aresetn;
    logic       locked;
    logic       lock_lost;
    logic       fail;
    logic [2:0] retry_cnt;
    logic [1:0] ctrl_state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_n = 0;

    dru_lock_ctrl #(
        .RST_CYCLES   (RST_CYCLES),
        .WIN_LOG2     (WIN_LOG2),
        .MIN_EDGES    (MIN_EDGES),
        .MAX_SLIPS    (MAX_SLIPS),
        .LOCK_WINDOWS (LOCK_WINDOWS),
        .LOSS_WINDOWS (LOSS_WINDOWS),
        .ACQ_TIMEOUT  (ACQ_TIMEOUT),
        .MAX_RETRIES  (MAX_RETRIES)
    ) dut (
        .clk         (clk),
        .areset      (areset),
        .restart     (restart),
        .edge_flags  (edge_flags),
        .dru_phase   (dru_phase),
        .dru_aresetn (dru_aresetn),
        .locked      (locked),
        .lock_lost   (lock_lost),
        .fail        (fail),
        .retry_cnt   (retry_cnt),
        .ctrl_state  (ctrl_state)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 RESET, 1 ACQ, 2 LOCKED, 3 FAIL; the current
    // window is kept as a list of per-cycle samples and judged when full.
    int         m_state, m_rcyc, m_retry, m_good, m_bad, m_wins;
    bit         m_lost;
    logic [1:0] m_prev;
    bit         wq_e[$];
    bit         wq_s[$];

    function automatic void model_reset();
        m_state = 0; m_rcyc = 0; m_retry = 0; m_good = 0; m_bad = 0; m_wins = 0;
        m_lost = 0; m_prev = 2'b0;
        wq_e.delete(); wq_s.delete();
    endfunction

    function automatic void model_step(input bit rs, input bit e, input logic [1:0] ph);
        bit slip;
        int ne, ns;
        bit good;
        slip   = (ph != m_prev);
        m_prev = ph;
        m_lost = 0;
        if (rs) begin
            m_state = 0; m_rcyc = 0; m_retry = 0; m_good = 0; m_bad = 0; m_wins = 0;
            wq_e.delete(); wq_s.delete();
            return;
        end
        if (m_state == 0) begin
            m_rcyc++;
            if (m_rcyc == RST_CYCLES) begin
                m_state = 1; m_rcyc = 0; m_good = 0; m_bad = 0; m_wins = 0;
            end
        end else if (m_state == 1 || m_state == 2) begin
            wq_e.push_back(e);
            wq_s.push_back(slip);
            if (wq_e.size() == WIN) begin
                ne = 0; ns = 0;
                foreach (wq_e[i]) ne += int'(wq_e[i]);
                foreach (wq_s[i]) ns += int'(wq_s[i]);
                wq_e.delete(); wq_s.delete();
                good = (ne >= MIN_EDGES) && (ns <= MAX_SLIPS);
                if (m_state == 1) begin
                    m_wins++;
                    m_good = good ? m_good + 1 : 0;
                    if (m_good == LOCK_WINDOWS) begin
                        m_state = 2; m_retry = 0; m_good = 0; m_bad = 0; m_wins = 0;
                    end else if (m_wins == ACQ_TIMEOUT) begin
                        m_retry++; m_wins = 0; m_good = 0;
                        m_state = (m_retry == MAX_RETRIES) ? 3 : 0;
                    end
                end else begin
                    m_bad = good ? 0 : m_bad + 1;
                    if (m_bad == LOSS_WINDOWS) begin
                        m_state = 0; m_lost = 1; m_bad = 0;
                    end
                end
            end
        end
    endfunction

    function automatic logic [8:0] model_vec();
        logic arn, lk, fl;
        arn = (m_state == 1) || (m_state == 2);
        lk  = (m_state == 2);
        fl  = (m_state == 3);
        return {arn, lk, m_lost, fl, 3'(m_retry), 2'(m_state)};
    endfunction

    function automatic logic [8:0] dut_vec();
        return {dru_aresetn, locked, lock_lost, fail, retry_cnt, ctrl_state};
    endfunction

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: {aresetn,locked,lost,fail,retry,state} got=%b required=%b",
                     name, got, exp);
        end
    endtask

    // One clock: drive inputs while clk is low, advance the model on the edge,
    // compare on the falling edge.
    task automatic cyc(input bit rs, input logic [3:0] ef, input logic [1:0] ph);
        restart    = rs;
        edge_flags = ef;
        dru_phase  = ph;
        @(posedge clk);
        model_step(rs, ef != 4'b0, ph);
        cyc_n++;
        @(negedge clk);
        check($sformatf("model_c%0d", cyc_n), dut_vec(), model_vec());
    endtask

    function automatic logic [3:0] edge_for(input int em, input int n);
        if (em == 1) return (n % 2 == 0) ? 4'b0001 : 4'b0000;
        return 4'b0000;
    endfunction

    function automatic logic [1:0] phase_for(input int pm, input int n);
        if (pm == 1) return 2'((n / 4) % 2);
        if (pm == 2) return 2'((n / 16) % 4);
        return 2'b00;
    endfunction

    typedef struct {
        int         n;
        bit         rs;
        int         em;
        int         pm;
        logic [1:0] st;
        logic [2:0] rt;
        logic       lk;
        logic       lost;
        logic       fl;
        logic       arn;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int dens, chg;
        logic [3:0] ef;
        logic [1:0] ph;
        bit rs;

        // Rows run back to back from reset release; cycle numbers in notes
        // are the cycle observed after the row. ACQ starts at cycle 4.
        tbl[0]  = '{35, 1'b0, 1, 0, 2'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1}; // 2nd window ends cycle 35
        tbl[1]  = '{1,  1'b0, 1, 0, 2'd2, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1}; // locked at 36
        tbl[2]  = '{32, 1'b0, 0, 0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}; // two bad windows -> lost
        tbl[3]  = '{1,  1'b0, 0, 0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0}; // pulse is one cycle
        tbl[4]  = '{3,  1'b0, 0, 0, 2'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1}; // reset held 4 cycles
        tbl[5]  = '{48, 1'b0, 1, 1, 2'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0}; // first timeout
        tbl[6]  = '{52, 1'b0, 1, 1, 2'd3, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0}; // second timeout -> FAIL
        tbl[7]  = '{10, 1'b0, 1, 0, 2'd3, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0}; // FAIL is sticky
        tbl[8]  = '{1,  1'b1, 1, 2, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0}; // restart clears
        tbl[9]  = '{3,  1'b0, 1, 2, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1,  1'b0, 1, 2, 2'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1}; // ACQ after 4 reset cycles
        tbl[11] = '{31, 1'b0, 1, 2, 2'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1}; // 3->0 wrap is one slip
        tbl[12] = '{1,  1'b0, 1, 2, 2'd2, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        areset = 1'b0;
        model_reset();
        cyc_n = 0;
        #1;
        check("reset_values", dut_vec(), 9'b0);

        for (int r = 0; r < 13; r++) begin
            for (int k = 0; k < tbl[r].n; k++) begin
                cyc(tbl[r].rs && (k == 0), edge_for(tbl[r].em, cyc_n), phase_for(tbl[r].pm, cyc_n));
            end
            check($sformatf("row%0d", r), dut_vec(),
                  {tbl[r].arn, tbl[r].lk, tbl[r].lost, tbl[r].fl, tbl[r].rt, tbl[r].st});
        end

        // Asynchronous reset while LOCKED, checked before any clock edge.
        areset = 1'b1;
        #1;
        check("async_reset_locked", dut_vec(), 9'b0);
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_hold", dut_vec(), 9'b0);
        areset = 1'b0;
        cyc_n  = 0;

        // Randomized traffic in segments of varying edge density and phase wander.
        for (int seg = 0; seg < 40; seg++) begin
            dens = int'($urandom_range(0, 8));
            chg  = int'($urandom_range(0, 4));
            for (int k = 0; k < 64; k++) begin
                rs = ($urandom_range(0, 399) == 0);
                ef = (int'($urandom_range(0, 7)) < dens) ? 4'($urandom_range(1, 15)) : 4'b0;
                ph = (int'($urandom_range(0, 31)) < chg) ? 2'($urandom_range(0, 3)) : dru_phase;
                cyc(rs, ef, ph);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
